roam_grid_ctrl: RTL and testbench
=================================

ROAM_GRID_CTRL -- requirements
Module: roam_grid_ctrl

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- NUM_NPC, 5: number of NPC slots.
- TILE, 16: pixels per grid step.
- MAP_X, 300: map left edge, in pixels.
- MAP_Y, 100: map top edge, in pixels.
- MAP_W, 192: map width, in pixels.
- MAP_H, 256: map height, in pixels.
- START_X, 396: player spawn x.
- START_Y, 324: player spawn y.
- IDXW, 3: width of battle_idx.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-low reset; 0 = reset.
- frame_clk, in, 1: vertical-sync frame clock.
- is_roam, in, 1: roam mode enable.
- keycode, in, 8: current key. W=0x1A, A=0x04, S=0x16, D=0x07, ENTER=0x28.
- npc_x, in, 10*NUM_NPC: packed NPC x positions; slot i is at bits [10i+9:10i].
- npc_y, in, 10*NUM_NPC: packed NPC y positions, same packing.
- npc_active, in, NUM_NPC: NPC present; an active NPC blocks movement.
- npc_defeated, in, NUM_NPC: NPC already beaten.
- battle_ack, in, 1: battle engine accepted the request.
- player_x, out, 10: player top-left x.
- player_y, out, 10: player top-left y.
- player_dir, out, 2: facing direction. 0 = up (back), 1 = down (front), 2 = left, 3 = right.
- walk_phase, out, 2: animation frame.
- moving, out, 1: high while in WALK.
- start_battle, out, 1: battle request.
- battle_idx, out, IDXW: index of the challenged NPC.

Function
REQ-003 The block SHALL register a frame tick: a one-Clk pulse, one cycle after a frame_clk 0→1 edge is sampled.
REQ-004 The FSM states SHALL be IDLE, WALK and BREQ.
REQ-005 IDLE handling on a tick with a W/A/S/D key: if the key direction differs from player_dir, player_dir SHALL update and the state SHALL stay IDLE (turn only, no motion).
REQ-006 IDLE handling on a tick with a W/A/S/D key whose direction equals player_dir: the target SHALL be the player position ± TILE along that axis.
REQ-007 The move SHALL be legal only if both hold:
- MAP_X ≤ tx and tx+TILE ≤ MAP_X+MAP_W, and MAP_Y ≤ ty and ty+TILE ≤ MAP_Y+MAP_H;
- no active NPC i has (npc_x[i], npc_y[i]) == (tx, ty).
REQ-008 Bound arithmetic SHALL be 11-bit signed-safe, so that x−TILE below 0 is rejected and never wraps to a legal value.
REQ-009 A legal move SHALL enter WALK with step counter 0; an illegal move SHALL stay IDLE with position unchanged.
REQ-010 WALK: each tick SHALL move the player 1 px toward the target and increment the counter; after TILE ticks the position SHALL equal the target exactly and the state SHALL return to IDLE.
REQ-011 In WALK, keycode SHALL be ignored, including ENTER and direction keys.
REQ-012 moving SHALL be 1 in WALK only.
REQ-013 walk_phase SHALL equal counter[3:2] in WALK and 0 otherwise.
REQ-014 Interaction (evaluated every Clk in IDLE, independent of tick): if keycode==ENTER and the faced tile equals the position of an NPC that is active and not defeated, the FSM SHALL enter BREQ.
REQ-015 On entering BREQ, battle_idx SHALL be the lowest matching index.
REQ-016 start_battle SHALL be registered: 1 from the cycle after BREQ entry.
REQ-017 start_battle SHALL be held high while in BREQ and movement SHALL be frozen there.
REQ-018 In BREQ, battle_ack=1 SHALL return the FSM to IDLE, with start_battle 0 on the next cycle.
REQ-019 battle_idx SHALL hold its value until the next BREQ entry.
REQ-020 An NPC that is defeated but active SHALL still block movement and SHALL never trigger BREQ.
REQ-021 ENTER with no eligible faced NPC SHALL have no effect.
REQ-022 battle_ack outside BREQ SHALL be ignored.
REQ-023 is_roam=0 SHALL synchronously force the reset state of REQ-025 on every cycle it is low, aborting WALK or BREQ.
REQ-024 Changes to npc_* during WALK SHALL NOT alter the move already in progress.

Reset
REQ-025 When Reset=0 at a Clk edge, the block SHALL set:
- state IDLE;
- player_x=START_X, player_y=START_Y, player_dir=0;
- walk_phase=0, moving=0;
- start_battle=0, battle_idx=0;
- step counter 0 and tick register 0.
REQ-026 Reset SHALL take priority over is_roam and all other inputs.

Verification
REQ-027 Turn then walk: dir=0, hold D for 17 ticks. Required: tick 1 sets dir=3; over ticks 2–17, x goes 397…412; moving=0 afterward.
REQ-028 Wall: player at x=300 facing left, A held for 3 ticks. Required: x stays 300, no WALK entry, no 10-bit wrap.
REQ-029 Block and battle: NPC 2 active at (396,308), player at (396,324) with dir=0.
- W held: player stays put.
- ENTER: start_battle=1 and battle_idx=2 from the next cycle, held 10 cycles without ack.
- battle_ack pulse: start_battle=0 one cycle later.
REQ-030 Defeated NPC: same setup as REQ-029 with npc_defeated[2]=1. Required: ENTER gives no start_battle, and W is still blocked.
REQ-031 Abort: is_roam=0 mid-WALK (tick 8). Required: next cycle x=396, y=324, dir=0, moving=0.
REQ-032 Reset mid-BREQ: Reset=0 for 1 cycle. Required: start_battle=0 and all outputs at REQ-025 values the next cycle.

Source files
------------

// File: rtl/roam_grid_ctrl.sv
// Grid-based overworld player controller: tile-stepped walking with turn-in-place,
// map/NPC collision and an ENTER-triggered battle request handshake.
module roam_grid_ctrl #(
    parameter int NUM_NPC = 5,
    parameter int TILE    = 16,
    parameter int MAP_X   = 300,
    parameter int MAP_Y   = 100,
    parameter int MAP_W   = 192,
    parameter int MAP_H   = 256,
    parameter int START_X = 396,
    parameter int START_Y = 324,
    parameter int IDXW    = 3
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    is_roam,
    input  logic [7:0]              keycode,
    input  logic [10*NUM_NPC-1:0]   npc_x,
    input  logic [10*NUM_NPC-1:0]   npc_y,
    input  logic [NUM_NPC-1:0]      npc_active,
    input  logic [NUM_NPC-1:0]      npc_defeated,
    input  logic                    battle_ack,
    output logic [9:0]              player_x,
    output logic [9:0]              player_y,
    output logic [1:0]              player_dir,
    output logic [1:0]              walk_phase,
    output logic                    moving,
    output logic                    start_battle,
    output logic [IDXW-1:0]         battle_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_BREQ = 2'd2;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Coordinates are widened to 12-bit signed so x-TILE near 0 goes negative instead of wrapping.
    localparam int CW   = 12;
    localparam int CNTW = ($clog2(TILE + 1) < 4) ? 4 : $clog2(TILE + 1);

    localparam logic signed [CW-1:0] TILE_S   = CW'(TILE);
    localparam logic signed [CW-1:0] X_LO_S   = CW'(MAP_X);
    localparam logic signed [CW-1:0] X_HI_S   = CW'(MAP_X + MAP_W);
    localparam logic signed [CW-1:0] Y_LO_S   = CW'(MAP_Y);
    localparam logic signed [CW-1:0] Y_HI_S   = CW'(MAP_Y + MAP_H);

    function automatic logic signed [CW-1:0] ext(input logic [9:0] v);
        return $signed({{(CW-10){1'b0}}, v});
    endfunction

    function automatic logic in_map(input logic signed [CW-1:0] x, input logic signed [CW-1:0] y);
        return (x >= X_LO_S) && (x + TILE_S <= X_HI_S) && (y >= Y_LO_S) && (y + TILE_S <= Y_HI_S);
    endfunction

    logic [1:0]             state;
    logic                   fc_p0;
    logic                   tick_p1;
    logic [CNTW-1:0]        cnt;
    logic [9:0]             tgt_x;
    logic [9:0]             tgt_y;

    logic                   key_is_dir;
    logic [1:0]             key_dir;
    logic signed [CW-1:0]   tx;
    logic signed [CW-1:0]   ty;
    logic [9:0]             nxt_x;
    logic [9:0]             nxt_y;
    logic                   blocked;
    logic                   hit;
    logic [IDXW-1:0]        hit_idx;
    logic                   legal;

    always_comb begin
        key_is_dir = 1'b1;
        key_dir    = 2'd0;
        case (keycode)
            KEY_W:   key_dir = 2'd0;
            KEY_S:   key_dir = 2'd1;
            KEY_A:   key_dir = 2'd2;
            KEY_D:   key_dir = 2'd3;
            default: key_is_dir = 1'b0;
        endcase
    end

    // The faced tile doubles as the move target: a move only happens when key_dir == player_dir.
    always_comb begin
        tx    = ext(player_x);
        ty    = ext(player_y);
        nxt_x = player_x;
        nxt_y = player_y;
        case (player_dir)
            2'd0: begin ty = ext(player_y) - TILE_S; nxt_y = player_y - 10'd1; end
            2'd1: begin ty = ext(player_y) + TILE_S; nxt_y = player_y + 10'd1; end
            2'd2: begin tx = ext(player_x) - TILE_S; nxt_x = player_x - 10'd1; end
            default: begin tx = ext(player_x) + TILE_S; nxt_x = player_x + 10'd1; end
        endcase
    end

    always_comb begin
        blocked = 1'b0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_NPC - 1; i >= 0; i--) begin
            if (ext(npc_x[10*i +: 10]) == tx && ext(npc_y[10*i +: 10]) == ty && npc_active[i]) begin
                blocked = 1'b1;
                if (!npc_defeated[i]) begin
                    hit     = 1'b1;
                    hit_idx = IDXW'(i);
                end
            end
        end
        legal = in_map(tx, ty) && !blocked;
    end

    assign moving     = (state == S_WALK);
    assign walk_phase = moving ? cnt[3:2] : 2'd0;

    // Control and position state; is_roam low behaves as a reset.
    always_ff @(posedge Clk) begin
        if (!Reset || !is_roam) begin
            state        <= S_IDLE;
            fc_p0        <= 1'b0;
            tick_p1      <= 1'b0;
            cnt          <= '0;
            player_x     <= 10'(START_X);
            player_y     <= 10'(START_Y);
            player_dir   <= 2'd0;
            start_battle <= 1'b0;
            battle_idx   <= '0;
        end else begin
            fc_p0   <= frame_clk;
            tick_p1 <= frame_clk & ~fc_p0;
            case (state)
                S_IDLE: begin
                    if (keycode == KEY_ENTER && hit) begin
                        state        <= S_BREQ;
                        start_battle <= 1'b1;
                        battle_idx   <= hit_idx;
                    end else if (tick_p1 && key_is_dir) begin
                        if (key_dir != player_dir) begin
                            player_dir <= key_dir;
                        end else if (legal) begin
                            // The entry tick already takes the first pixel of the step.
                            state    <= S_WALK;
                            cnt      <= '0;
                            player_x <= nxt_x;
                            player_y <= nxt_y;
                        end
                    end
                end
                S_WALK: begin
                    if (tick_p1) begin
                        if (cnt == CNTW'(TILE - 2)) begin
                            state    <= S_IDLE;
                            cnt      <= '0;
                            player_x <= tgt_x;
                            player_y <= tgt_y;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            player_x <= nxt_x;
                            player_y <= nxt_y;
                        end
                    end
                end
                S_BREQ: begin
                    if (battle_ack) begin
                        state        <= S_IDLE;
                        start_battle <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Target latched at walk entry so later NPC changes cannot disturb the step.
    always_ff @(posedge Clk) begin
        if (state == S_IDLE) begin
            tgt_x <= tx[9:0];
            tgt_y <= ty[9:0];
        end
    end

endmodule

// File: tb/tb_roam_grid_ctrl.sv
// Scoreboard bench for roam_grid_ctrl: directed scenarios plus randomized roaming,
// checked every cycle against a tile/pixel-level reference model.
module tb_roam_grid_ctrl;

    localparam int NUM_NPC = 5;
    localparam int TILE    = 16;
    localparam int MAP_X   = 300;
    localparam int MAP_Y   = 100;
    localparam int MAP_W   = 192;
    localparam int MAP_H   = 256;
    localparam int START_X = 396;
    localparam int START_Y = 324;
    localparam int IDXW    = 3;

    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_ENTER = 8'h28;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  frame_clk;
    logic                  is_roam;
    logic [7:0]            keycode;
    logic [10*NUM_NPC-1:0] npc_x;
    logic [10*NUM_NPC-1:0] npc_y;
    logic [NUM_NPC-1:0]    npc_active;
    logic [NUM_NPC-1:0]    npc_defeated;
    logic                  battle_ack;
    logic [9:0]            player_x;
    logic [9:0]            player_y;
    logic [1:0]            player_dir;
    logic [1:0]            walk_phase;
    logic                  moving;
    logic                  start_battle;
    logic [IDXW-1:0]       battle_idx;

    roam_grid_ctrl #(
        .NUM_NPC(NUM_NPC), .TILE(TILE), .MAP_X(MAP_X), .MAP_Y(MAP_Y), .MAP_W(MAP_W),
        .MAP_H(MAP_H), .START_X(START_X), .START_Y(START_Y), .IDXW(IDXW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .is_roam(is_roam), .keycode(keycode),
        .npc_x(npc_x), .npc_y(npc_y), .npc_active(npc_active), .npc_defeated(npc_defeated),
        .battle_ack(battle_ack), .player_x(player_x), .player_y(player_y),
        .player_dir(player_dir), .walk_phase(walk_phase), .moving(moving),
        .start_battle(start_battle), .battle_idx(battle_idx)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0]      x;
        logic [9:0]      y;
        logic [1:0]      dir;
        logic [1:0]      phase;
        logic            mv;
        logic            sb;
        logic [IDXW-1:0] idx;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pixel position, facing, walk progress, battle flag.
    int mx, my, mdir, mtx, mty, mmoved, midx;
    bit mwalk, mbattle, mfc, mtick;

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic bit key_dir(input logic [7:0] k, output int d);
        d = 0;
        case (k)
            K_W: begin d = 0; return 1'b1; end
            K_S: begin d = 1; return 1'b1; end
            K_A: begin d = 2; return 1'b1; end
            K_D: begin d = 3; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit npc_at(input int i, input int x, input int y);
        return int'(npc_x[10*i +: 10]) == x && int'(npc_y[10*i +: 10]) == y;
    endfunction

    task automatic model_step();
        bit tick_now, hit, blocked;
        int fx, fy, kd;
        if (!Reset || !is_roam) begin
            mx = START_X; my = START_Y; mdir = 0;
            mwalk = 0; mbattle = 0; midx = 0; mmoved = 0;
            mfc = 0; mtick = 0;
        end else begin
            tick_now = mtick;
            mtick    = frame_clk && !mfc;
            mfc      = frame_clk;
            if (mbattle) begin
                if (battle_ack) mbattle = 0;
            end else if (mwalk) begin
                if (tick_now) begin
                    mx += sgn(mtx - mx);
                    my += sgn(mty - my);
                    mmoved++;
                    if (mmoved == TILE) mwalk = 0;
                end
            end else begin
                fx = mx; fy = my;
                case (mdir)
                    0: fy -= TILE;
                    1: fy += TILE;
                    2: fx -= TILE;
                    default: fx += TILE;
                endcase
                if (keycode == K_ENTER) begin
                    hit = 0;
                    for (int i = 0; i < NUM_NPC; i++)
                        if (!hit && npc_active[i] && !npc_defeated[i] && npc_at(i, fx, fy)) begin
                            hit = 1; midx = i; mbattle = 1;
                        end
                end else if (tick_now && key_dir(keycode, kd)) begin
                    if (kd != mdir) begin
                        mdir = kd;
                    end else begin
                        blocked = 0;
                        for (int i = 0; i < NUM_NPC; i++)
                            if (npc_active[i] && npc_at(i, fx, fy)) blocked = 1;
                        if (!blocked && fx >= MAP_X && fx + TILE <= MAP_X + MAP_W &&
                            fy >= MAP_Y && fy + TILE <= MAP_Y + MAP_H) begin
                            mwalk = 1; mtx = fx; mty = fy; mmoved = 1;
                            mx += sgn(fx - mx);
                            my += sgn(fy - my);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        obs_t e;
        forever begin
            @(posedge Clk);
            model_step();
            e.x     = 10'(mx);
            e.y     = 10'(my);
            e.dir   = 2'(mdir);
            e.phase = mwalk ? 2'(((mmoved - 1) / 4) % 4) : 2'd0;
            e.mv    = mwalk;
            e.sb    = mbattle;
            e.idx   = IDXW'(midx);
            exp_q.push_back(e);
        end
    end

    initial begin
        obs_t e, a;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {player_x, player_y, player_dir, walk_phase, moving, start_battle, battle_idx};
                checks++;
                if (a !== e)
                    begin
                    errors++;
                    $display("FAIL outputs t=%0t got x=%0d y=%0d dir=%0d ph=%0d mv=%0b sb=%0b idx=%0d expected x=%0d y=%0d dir=%0d ph=%0d mv=%0b sb=%0b idx=%0d",
                             $time, a.x, a.y, a.dir, a.phase, a.mv, a.sb, a.idx,
                             e.x, e.y, e.dir, e.phase, e.mv, e.sb, e.idx);
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: stimulus did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic chk_reset();
        checks++;
        if (player_x !== 10'(START_X) || player_y !== 10'(START_Y) || player_dir !== 2'd0 ||
            walk_phase !== 2'd0 || moving !== 1'b0 || start_battle !== 1'b0 ||
            battle_idx !== '0) begin
            errors++;
            $display("FAIL reset state t=%0t x=%0d y=%0d dir=%0d ph=%0d mv=%0b sb=%0b idx=%0d",
                     $time, player_x, player_y, player_dir, walk_phase, moving,
                     start_battle, battle_idx);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        cyc(2);
        frame_clk = 1'b0;
        cyc(2);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic set_npc(input int i, input int x, input int y, input bit act, input bit def);
        npc_x[10*i +: 10] = 10'(x);
        npc_y[10*i +: 10] = 10'(y);
        npc_active[i]     = act;
        npc_defeated[i]   = def;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0; keycode = 8'h00; battle_ack = 1'b0; frame_clk = 1'b0; is_roam = 1'b1;
        npc_x = '0; npc_y = '0; npc_active = '0; npc_defeated = '0;
        cyc(2);
        chk_reset();
        Reset = 1'b1;
    endtask

    localparam logic [7:0] KEYS [6] = '{K_W, K_A, K_S, K_D, K_ENTER, 8'h00};

    initial begin
        int s, px, py;
        Reset = 1'b0; is_roam = 1'b1; frame_clk = 1'b0; keycode = 8'h00; battle_ack = 1'b0;
        npc_x = '0; npc_y = '0; npc_active = '0; npc_defeated = '0;
        cyc(3);
        chk_reset();
        Reset = 1'b1;

        // Turn right, then one full step to x=412.
        keycode = K_D; frames(18); keycode = 8'h00; frames(2);

        // Walk left to the wall at x=300 and keep pushing against it.
        do_reset();
        keycode = K_A; frames(1 + 6 * 16 + 3); keycode = 8'h00; frames(1);

        // NPC 2 blocks the tile above; ENTER starts a battle held until ack.
        do_reset();
        set_npc(2, 396, 308, 1'b1, 1'b0);
        keycode = K_W; frames(3);
        keycode = K_ENTER; cyc(12);
        keycode = 8'h00; cyc(2);
        battle_ack = 1'b1; cyc(1); battle_ack = 1'b0; cyc(3);

        // Same NPC already defeated: no battle, still blocking.
        do_reset();
        set_npc(2, 396, 308, 1'b1, 1'b1);
        keycode = K_ENTER; cyc(4);
        keycode = K_W; frames(3); keycode = 8'h00;

        // Leaving roam mode in the middle of a step.
        do_reset();
        keycode = K_W; frames(8);
        is_roam = 1'b0; cyc(1); is_roam = 1'b1;
        keycode = 8'h00; frames(2);

        // Reset while the battle request is pending.
        do_reset();
        set_npc(2, 396, 308, 1'b1, 1'b0);
        keycode = K_ENTER; cyc(3); keycode = 8'h00;
        Reset = 1'b0; cyc(1); Reset = 1'b1; cyc(3);

        // Randomized roaming, with NPCs often placed next to the player.
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            @(negedge Clk);
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 7) == 0) keycode = KEYS[$urandom_range(0, 5)];
            battle_ack = ($urandom_range(0, 9) == 0);
            is_roam    = ($urandom_range(0, 399) != 0);
            Reset      = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 149) == 0) begin
                for (int i = 0; i < NUM_NPC; i++)
                    set_npc(i, START_X + 16 * ($urandom_range(0, 11) - 6),
                            START_Y + 16 * ($urandom_range(0, 15) - 14),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 59) == 0) begin
                s  = $urandom_range(0, NUM_NPC - 1);
                px = mx; py = my;
                case ($urandom_range(0, 3))
                    0: py -= TILE;
                    1: py += TILE;
                    2: px -= TILE;
                    default: px += TILE;
                endcase
                set_npc(s, px, py, 1'b1, 1'($urandom_range(0, 3) == 0));
            end
        end
        Reset = 1'b1; is_roam = 1'b1; battle_ack = 1'b0;
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
